// File: rtl/nonce_scheduler_pkg.sv
// Shared widths and state encoding for the nonce scheduler slice.
//   NS_WORD_S   : nonce / word width
//   NS_H_SIZE   : hash width
//   NS_MAX_INFL : deepest in-flight nonce count the scheduler must track
//   ns_state_e  : scheduler FSM states
package nonce_scheduler_pkg;

  localparam int NS_WORD_S   = 32;
  localparam int NS_H_SIZE   = 256;
  localparam int NS_MAX_INFL = 256;
  localparam int NS_LANE_W   = 32;

  typedef enum logic [1:0] {
    NS_IDLE  = 2'd0,
    NS_ISSUE = 2'd1,
    NS_FLUSH = 2'd2,
    NS_DONE  = 2'd3
  } ns_state_e;

endpackage

// File: rtl/nonce_scheduler_if.sv
// Link between the nonce scheduler and the pipelined SHA block.
//   sha_en       : issue strobe into the SHA pipeline
//   sha_nonce    : nonce issued with sha_en
//   sha_valid    : result valid from the SHA pipeline
//   sha_nonce_in : nonce belonging to the returned result
//   sha_H        : returned hash, bit NS_H_SIZE-1 is the MSB
// master = scheduler side, slave = SHA block side.
interface nonce_scheduler_if;
  import nonce_scheduler_pkg::*;

  logic                 sha_en;
  logic [NS_WORD_S-1:0] sha_nonce;
  logic                 sha_valid;
  logic [NS_WORD_S-1:0] sha_nonce_in;
  logic [NS_H_SIZE-1:0] sha_H;

  modport master (
    output sha_en, sha_nonce,
    input  sha_valid, sha_nonce_in, sha_H
  );

  modport slave (
    input  sha_en, sha_nonce,
    output sha_valid, sha_nonce_in, sha_H
  );

endinterface

// File: rtl/nonce_scheduler_hash_lt_target.sv
// Combinational unsigned magnitude compare lt = (a < b) on H_SIZE-bit
// vectors. The compare is cut into LANE_W-bit lanes evaluated in parallel,
// then merged by significance so no single long carry chain is needed.
//   a  : hash value
//   b  : target value
//   lt : 1 when a < b (unsigned)
module hash_lt_target
  import nonce_scheduler_pkg::*;
#(
  parameter int H_SIZE = NS_H_SIZE,
  parameter int LANE_W = NS_LANE_W
) (
  input  logic [H_SIZE-1:0] a,
  input  logic [H_SIZE-1:0] b,
  output logic              lt
);

  localparam int LANES = H_SIZE / LANE_W;

  logic [LANES-1:0] lane_lt_s;
  logic [LANES-1:0] lane_eq_s;

  // Independent per-lane less-than and equality
  always_comb begin
    lane_lt_s = '0;
    lane_eq_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_lt_s[i] = (a[i*LANE_W +: LANE_W] < b[i*LANE_W +: LANE_W]);
      lane_eq_s[i] = (a[i*LANE_W +: LANE_W] == b[i*LANE_W +: LANE_W]);
    end
  end

  // Merge from LSB lane upward: a lane decides unless it is equal, then the
  // verdict of the less significant lanes passes through
  always_comb begin
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      acc = lane_lt_s[i] | (lane_eq_s[i] & acc);
    end
    lt = acc;
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Sequences a pipelined SHA block: issues one nonce per cycle over the
// inclusive range [nonce_start, nonce_end] (wrapping through all-ones),
// tracks in-flight nonces, checks each returned hash against target and
// reports the first winning nonce, range exhaustion or abort.
//   clk, reset   : clock, synchronous active-high reset
//   start        : pulse, latch range/target and begin a run (ignored while busy)
//   abort        : pulse, stop issuing and drain, run ends with aborted set
//   nonce_start  : first nonce (inclusive)
//   nonce_end    : last nonce (inclusive)
//   target       : hit when returned hash < target (unsigned)
//   sha          : issue / result link to the SHA block (master side)
//   busy         : run in progress (issuing or draining)
//   done         : run finished, held until the next accepted start
//   found        : with done, a hit occurred
//   found_nonce  : nonce of the first hit
//   aborted      : with done, run was ended by abort
module nonce_scheduler
  import nonce_scheduler_pkg::*;
#(
  parameter int WORD_S   = NS_WORD_S,
  parameter int H_SIZE   = NS_H_SIZE,
  parameter int MAX_INFL = NS_MAX_INFL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_S-1:0] nonce_start,
  input  logic [WORD_S-1:0] nonce_end,
  input  logic [H_SIZE-1:0] target,
  nonce_scheduler_if.master sha,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [WORD_S-1:0] found_nonce,
  output logic              aborted
);

  localparam int INFL_W = $clog2(MAX_INFL + 1);

  ns_state_e         state_r;
  logic [WORD_S-1:0] cur_r;
  logic [WORD_S-1:0] end_r;
  logic [H_SIZE-1:0] target_r;
  logic [INFL_W-1:0] inflight_r;
  logic              found_pending_r;
  logic              abort_flag_r;
  logic [WORD_S-1:0] found_nonce_r;
  logic              sha_en_r;
  logic              busy_r;
  logic              done_r;
  logic              found_r;
  logic              aborted_r;

  logic              h_lt_s;
  logic              valid_ok_s;
  logic              hit_s;
  logic              abort_set_s;
  logic [INFL_W-1:0] inflight_nxt_s;

  hash_lt_target #(
    .H_SIZE (H_SIZE),
    .LANE_W (NS_LANE_W)
  ) u_cmp (
    .a  (sha.sha_H),
    .b  (target_r),
    .lt (h_lt_s)
  );

  // Qualify returned results and decide whether this cycle records a hit or an abort
  always_comb begin
    // A result with nothing in flight cannot belong to this run
    valid_ok_s = sha.sha_valid && (inflight_r != '0);
    hit_s      = valid_ok_s && h_lt_s && !found_pending_r;
    if ((state_r == NS_ISSUE) || (state_r == NS_FLUSH)) begin
      abort_set_s = abort && !found_pending_r && !hit_s;
    end else begin
      abort_set_s = 1'b0;
    end
  end

  // In-flight count: an issue and a retire in the same cycle cancel out
  always_comb begin
    inflight_nxt_s = inflight_r;
    if (sha_en_r && !valid_ok_s) begin
      inflight_nxt_s = inflight_r + INFL_W'(1);
    end else if (!sha_en_r && valid_ok_s) begin
      inflight_nxt_s = inflight_r - INFL_W'(1);
    end else begin
      inflight_nxt_s = inflight_r;
    end
  end

  // Scheduler FSM with nonce counter, hit latch and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= NS_IDLE;
      cur_r           <= '0;
      end_r           <= '0;
      target_r        <= '0;
      inflight_r      <= '0;
      found_pending_r <= 1'b0;
      abort_flag_r    <= 1'b0;
      found_nonce_r   <= '0;
      sha_en_r        <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      found_r         <= 1'b0;
      aborted_r       <= 1'b0;
    end else begin
      inflight_r <= inflight_nxt_s;
      if (hit_s) begin
        found_pending_r <= 1'b1;
        found_nonce_r   <= sha.sha_nonce_in;
      end
      if (abort_set_s) begin
        abort_flag_r <= 1'b1;
      end
      case (state_r)
        NS_IDLE, NS_DONE: begin
          // start beats a simultaneous abort here because abort is ignored when idle
          if (start) begin
            state_r         <= NS_ISSUE;
            cur_r           <= nonce_start;
            end_r           <= nonce_end;
            target_r        <= target;
            found_pending_r <= 1'b0;
            abort_flag_r    <= 1'b0;
            found_nonce_r   <= '0;
            sha_en_r        <= 1'b1;
            busy_r          <= 1'b1;
            done_r          <= 1'b0;
            found_r         <= 1'b0;
            aborted_r       <= 1'b0;
          end
        end
        NS_ISSUE: begin
          // cur_r is the nonce on the bus this cycle; that issue always completes
          if ((cur_r == end_r) || hit_s || abort) begin
            state_r  <= NS_FLUSH;
            sha_en_r <= 1'b0;
          end else begin
            cur_r <= cur_r + WORD_S'(1);
          end
        end
        NS_FLUSH: begin
          if ((inflight_r == '0) && !sha.sha_valid) begin
            state_r   <= NS_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            found_r   <= found_pending_r;
            aborted_r <= abort_flag_r | abort_set_s;
          end
        end
        default: begin
          state_r  <= NS_IDLE;
          sha_en_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign sha.sha_en    = sha_en_r;
  assign sha.sha_nonce = cur_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign found         = found_r;
  assign found_nonce   = found_nonce_r;
  assign aborted       = aborted_r;

endmodule
